// File: rtl/io_mux_arbiter_pkg.sv
// Shared definitions for the peripheral I/O read arbiter: FSM state encoding and
// default I/O width/count values also used by the read mux and I/O register bank.
package io_mux_arbiter_pkg;

  localparam int DEF_IO_COUNT  = 2;
  localparam int DEF_IO_WIDTH  = 8;
  localparam int DEF_SEL_WIDTH = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/io_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after last, wrapping.
// Shared between the read-side and write-side I/O arbiters.
module rr_pick #(
  parameter int R = 2,
  parameter int N = 1
) (
  input  logic [R-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick,
  output logic         any
);

  logic [R-1:0] upper;
  logic [R-1:0] upper_req;

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    upper = '0;
    for (int i = 0; i < R; i++) begin
      upper[i] = (i > int'(last));
    end
    upper_req = req & upper;
    pick = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (req[i]) pick = N'(i);
    end
    for (int i = R - 1; i >= 0; i--) begin
      if (upper_req[i]) pick = N'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/io_mux_arbiter.sv
// Round-robin read arbiter: drives the peripheral read mux select, captures its output
// and hands the data to the datapath over a valid/ack handshake.
module io_mux_arbiter
  import io_mux_arbiter_pkg::*;
#(
  parameter int R = DEF_IO_COUNT,
  parameter int T = DEF_IO_WIDTH,
  parameter int N = DEF_SEL_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [R-1:0] req,
  input  logic [T-1:0] mux_data,
  output logic [N-1:0] sel,
  output logic [R-1:0] grant,
  output logic [T-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ack
);

  if (2 ** N < R) begin : g_bad_sel_width
    $error("io_mux_arbiter: sel width N too small for R requesters");
  end

  state_t       state;
  logic [N-1:0] last;
  logic [N-1:0] pick;
  logic         any;

  rr_pick #(.R(R), .N(N)) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  // sel is registered one cycle ahead of capture so the external mux has a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      grant      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      last       <= N'(R - 1);
    end else begin
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            sel   <= pick;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          data_out   <= mux_data;
          grant      <= R'(1) << sel;
          data_valid <= 1'b1;
          last       <= sel;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (data_ack) begin
            data_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
